irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Request front-end that sits directly upstream of the 4-to-2 priority encoder stage.
- Captures rising edges on raw request lines into a pending register and exports that register as the encoder's input vector.
- Arbitrates the masked pending set, highest index first, and presents one request ID at a time to the consumer over a valid/ack handshake.
- Clears a pending bit only after its ID is acknowledged.

Parameters:
N, 4, number of request channels
IDW, 2, ID width; must equal ceil(log2(N))
TIMEOUT, 15, ack timeout in cycles; used only when IRQ_ACK_TIMEOUT_EN is defined

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  N  raw request lines, synchronous to clk
mask  input  N  per-channel enable; 1 = channel may be granted
pending  output  N  pending-request vector; feeds the priority encoder input
irq_valid  output  1  irq_id is valid
irq_id  output  IDW  index of the granted channel
irq_ack  input  1  consumer accepts irq_id
overrun  output  N  sticky flag: edge arrived while that channel was already pending
ovr_clr  input  1  clears all overrun bits
timeout  output  1  one-cycle pulse on ack timeout; tied 0 without the macro

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, overrun=0, req_q=0, irq_valid=0, irq_id=0, timeout=0, FSM=IDLE, timeout counter=0.
- Edge detect: req_q <= req each cycle; rise = req & ~req_q.
  - req_q resets to 0, so a line already high at reset release registers one edge on the first clock.
- Pending set: pending[i] <= 1 on rise[i], regardless of mask.
- Pending clear: pending[i] <= 0 when the handshake completes for ID i (irq_valid & irq_ack & irq_id==i).
  - If rise and clear hit the same channel in the same cycle, set wins and pending stays 1.
  - overrun is not set in this case.
- Overrun:
  - overrun[i] <= 1 on rise[i] while pending[i]=1 and the channel is not being cleared that cycle.
  - ovr_clr clears all bits.
  - If ovr_clr and a new overrun coincide, set wins.
- Arbitration: eligible = pending & mask; winner = highest set index (channel N-1 has top priority).
- FSM:
  - IDLE: if eligible != 0, register irq_id=winner and irq_valid=1, then go to PRESENT. Otherwise stay in IDLE with irq_valid=0.
  - PRESENT: irq_valid=1 and irq_id held stable.
    - Changes to mask or pending do not retract or change the ID.
    - When irq_ack=1, clear pending[irq_id], drive irq_valid=0 on the next edge, and go to IDLE.
- Latency:
  - req sampled high at edge k → pending set after edge k → irq_valid high after edge k+1.
  - After an ack, the minimum gap is one cycle with irq_valid=0 before the next grant.
- irq_ack while irq_valid=0 is ignored.
- Mid-operation reset aborts any grant immediately. All state returns to reset values and no pending bit survives.

Optional Feature:
- Macro: IRQ_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while in PRESENT and is cleared on entry to PRESENT.
  - If it reaches TIMEOUT cycles with no irq_ack, then on the next edge: irq_valid=0, FSM goes to IDLE, timeout pulses high for one cycle, and pending is left set.
  - Arbitration then reruns from IDLE.
  - An ack on the same cycle as the timeout takes priority: normal completion, no timeout pulse.
- Undefined: no counter; the FSM waits indefinitely in PRESENT; timeout is tied to 0.

Test Plan:
- Reset, then req=0000 → pending=0000, irq_valid=0, overrun=0000 for 10 cycles.
- mask=1111; pulse req=0100 → pending=0100 one cycle after the sample, irq_valid=1 with irq_id=2 one cycle later. Ack for one cycle → pending=0000, irq_valid=0.
- mask=1111; req rises to 1100 in one cycle → grant irq_id=3. After ack, one idle cycle, then irq_id=2. After ack, pending=0000.
- mask=0111, pending=1001 → irq_id=0 granted and channel 3 stays pending. Set mask=1111 during PRESENT → irq_id remains 0 until acked, then irq_id=3.
- Channel 1 pending; new edge on req[1] → overrun=0010. Pulse ovr_clr → overrun=0000. Edge on req[1] in the same cycle its ack completes → pending[1]=1, overrun=0000.
- IRQ_ACK_TIMEOUT_EN with TIMEOUT=15: grant irq_id=3 with no ack → irq_valid drops after 15 cycles, timeout pulses for one cycle, and irq_id=3 is re-granted on the following cycle. Assert rst_n low mid-PRESENT → all outputs 0 immediately.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// Request front-end: rising edges on req set pending bits, the masked pending set is arbitrated
// highest-index-first and presented over valid/ack. Optional ack timeout via IRQ_ACK_TIMEOUT_EN.
module irq_pending_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pending,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  input  logic           irq_ack,
  output logic [N-1:0]   overrun,
  input  logic           ovr_clr,
  output logic           timeout
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   req_q, rise, clr, eligible;
  logic [IDW-1:0] winner, irq_id_nxt;
  logic           irq_valid_nxt, grant_c, ack_c, to_hit;

  assign rise     = req & ~req_q;
  assign eligible = pending & mask;
  assign ack_c    = irq_valid & irq_ack;

  // One-hot clear for the channel whose handshake completes this cycle
  always_comb begin
    clr = '0;
    if (ack_c) clr[irq_id] = 1'b1;
  end

  // Highest eligible index wins; later iterations overwrite lower ones
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] to_cnt;

  // Counts completed PRESENT cycles; an ack in the expiry cycle takes precedence
  assign to_hit = (state == PRESENT) && !irq_ack && (to_cnt == CNTW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= ((state == PRESENT) && (state_nxt == PRESENT)) ? to_cnt + CNTW'(1) : '0;
      timeout <= to_hit;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT);
  assign to_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = PRESENT;
      PRESENT: if (irq_ack || to_hit) state_nxt = IDLE;
    endcase
  end

  // The ID is captured only on the IDLE->PRESENT transition and held while presented
  always_comb begin
    grant_c       = (state == IDLE) && (state_nxt == PRESENT);
    irq_valid_nxt = (state_nxt == PRESENT);
    irq_id_nxt    = grant_c ? winner : irq_id;
  end

  // A new edge beats a same-cycle clear, for both pending and overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending   <= '0;
      overrun   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      req_q     <= req;
      pending   <= (pending & ~clr) | rise;
      overrun   <= (ovr_clr ? '0 : overrun) | (rise & pending & ~clr);
      irq_valid <= irq_valid_nxt;
      irq_id    <= irq_id_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed steps from the test plan followed by random traffic,
// all checked against a channel-level reference model of pending/overrun/grant behaviour.
module tb_irq_pending_ctrl;
  localparam int unsigned N       = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   mask = '0;
  logic [N-1:0]   pending;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ack = 1'b0;
  logic [N-1:0]   overrun;
  logic           ovr_clr = 1'b0;
  logic           timeout;

  int checks = 0;
  int failures = 0;

  bit [N-1:0] m_pend, m_ovr, m_reqq;
  bit         m_valid, m_to;
  int         m_id, m_age;

  irq_pending_ctrl #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .pending(pending),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
    .overrun(overrun), .ovr_clr(ovr_clr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_reqq = '0;
    m_valid = 0; m_to = 0; m_id = 0; m_age = 0;
  endtask

  // One clock edge of the reference behaviour, evaluated from pre-edge model state and inputs
  task automatic model_edge();
    bit [N-1:0] np, no;
    bit done;
    int hi;
    done = m_valid && irq_ack;
    hi = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && mask[i]) hi = i;
    for (int i = 0; i < N; i++) begin
      bit rise_i, clr_i;
      rise_i = req[i] && !m_reqq[i];
      clr_i  = done && (m_id == i);
      np[i]  = rise_i || (m_pend[i] && !clr_i);
      no[i]  = (rise_i && m_pend[i] && !clr_i) || (m_ovr[i] && !ovr_clr);
    end
    m_to = 0;
    if (!m_valid) begin
      if (hi >= 0) begin m_valid = 1; m_id = hi; m_age = 1; end
    end else if (irq_ack) begin
      m_valid = 0;
    end
`ifdef IRQ_ACK_TIMEOUT_EN
    else if (m_age == int'(TIMEOUT)) begin m_valid = 0; m_to = 1; end
    else m_age++;
`endif
    m_pend = np; m_ovr = no; m_reqq = req;
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.pending", tag), 32'(pending), 32'(m_pend));
    chk($sformatf("%s.valid", tag), 32'(irq_valid), 32'(m_valid));
    if (m_valid) chk($sformatf("%s.id", tag), 32'(irq_id), 32'(m_id));
    chk($sformatf("%s.overrun", tag), 32'(overrun), 32'(m_ovr));
    chk($sformatf("%s.timeout", tag), 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] m,
                      input logic a, input logic c);
    req = r; mask = m; irq_ack = a; ovr_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asserted between edges so the asynchronous clear is observed without a clock
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_pending"}, 32'(pending), 32'h0);
    chk({tag, ".rst_valid"}, 32'(irq_valid), 32'h0);
    chk({tag, ".rst_id"}, 32'(irq_id), 32'h0);
    chk({tag, ".rst_overrun"}, 32'(overrun), 32'h0);
    chk({tag, ".rst_timeout"}, 32'(timeout), 32'h0);
    req = '0; mask = '0; irq_ack = 1'b0; ovr_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset("init");

    for (int i = 0; i < 10; i++) step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("idle.pending", 32'(pending), 32'h0);

    // Single request on channel 2
    step("c2.sample", 4'b0100, 4'b1111, 1'b0, 1'b0);
    chk("c2.pending", 32'(pending), 32'h4);
    chk("c2.nogrant", 32'(irq_valid), 32'h0);
    step("c2.grant", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("c2.valid", 32'(irq_valid), 32'h1);
    chk("c2.id", 32'(irq_id), 32'h2);
    step("c2.ack", 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("c2.cleared", 32'(pending), 32'h0);

    // Two simultaneous requests: 3 before 2, one idle cycle between
    step("c32.sample", 4'b1100, 4'b1111, 1'b0, 1'b0);
    step("c32.grant3", 4'b1100, 4'b1111, 1'b0, 1'b0);
    chk("c32.id3", 32'(irq_id), 32'h3);
    step("c32.ack3", 4'b1100, 4'b1111, 1'b1, 1'b0);
    chk("c32.gap", 32'(irq_valid), 32'h0);
    step("c32.grant2", 4'b1100, 4'b1111, 1'b0, 1'b0);
    chk("c32.id2", 32'(irq_id), 32'h2);
    step("c32.ack2", 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("c32.empty", 32'(pending), 32'h0);

    // Masked channel 3; unmasking mid-PRESENT must not change the presented ID
    step("msk.sample", 4'b1001, 4'b0111, 1'b0, 1'b0);
    chk("msk.pending", 32'(pending), 32'h9);
    step("msk.grant0", 4'b0000, 4'b0111, 1'b0, 1'b0);
    chk("msk.id0", 32'(irq_id), 32'h0);
    step("msk.hold1", 4'b0000, 4'b1111, 1'b0, 1'b0);
    step("msk.hold2", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("msk.still0", 32'(irq_id), 32'h0);
    step("msk.ack0", 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("msk.left3", 32'(pending), 32'h8);
    step("msk.grant3", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("msk.id3", 32'(irq_id), 32'h3);
    step("msk.ack3", 4'b0000, 4'b1111, 1'b1, 1'b0);

    // Overrun set, clear, and edge coinciding with ack
    step("ovr.sample", 4'b0010, 4'b0000, 1'b0, 1'b0);
    step("ovr.low", 4'b0000, 4'b0000, 1'b0, 1'b0);
    step("ovr.edge2", 4'b0010, 4'b0000, 1'b0, 1'b0);
    chk("ovr.set", 32'(overrun), 32'h2);
    step("ovr.clr", 4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("ovr.cleared", 32'(overrun), 32'h0);
    step("ovr.grant1", 4'b0000, 4'b0010, 1'b0, 1'b0);
    chk("ovr.id1", 32'(irq_id), 32'h1);
    step("ovr.ackedge", 4'b0010, 4'b0010, 1'b1, 1'b0);
    chk("ovr.keep_pend", 32'(pending), 32'h2);
    chk("ovr.no_ovr", 32'(overrun), 32'h0);
    step("ovr.regrant", 4'b0000, 4'b0010, 1'b0, 1'b0);
    chk("ovr.regrant_valid", 32'(irq_valid), 32'h1);
    do_reset("midpresent");

`ifdef IRQ_ACK_TIMEOUT_EN
    step("to.sample", 4'b1000, 4'b1111, 1'b0, 1'b0);
    step("to.grant", 4'b0000, 4'b1111, 1'b0, 1'b0);
    for (int i = 1; i < int'(TIMEOUT); i++) step("to.wait", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("to.still_valid", 32'(irq_valid), 32'h1);
    step("to.expire", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("to.drop", 32'(irq_valid), 32'h0);
    chk("to.pulse", 32'(timeout), 32'h1);
    chk("to.kept", 32'(pending), 32'h8);
    step("to.regrant", 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("to.pulse_end", 32'(timeout), 32'h0);
    chk("to.id3", 32'(irq_id), 32'h3);
    do_reset("to.midpresent");
`endif

    // Random traffic; sparse acks let the timeout path fire when enabled
    for (int i = 0; i < 1500; i++) begin
      step("rand", N'($urandom), (i % 7 == 0) ? N'($urandom) : mask,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0));
      if (i == 750) do_reset("rand.reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
